// File: rtl/softmax_pkg.sv
// Shared state encodings, default phase latencies and timer width for the
// softmax phase scheduler.
package softmax_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_READ  = 4'd1,
    S_EXPO  = 4'd2,
    S_ACC   = 4'd3,
    S_RECI  = 4'd4,
    S_FETCH = 4'd5,
    S_MULT  = 4'd6,
    S_STORE = 4'd7,
    S_DONE  = 4'd8
  } sched_state_e;

  localparam int unsigned DEF_ADDR_W   = 4;
  localparam int unsigned DEF_EXP_LAT  = 4;
  localparam int unsigned DEF_ACC_LAT  = 2;
  localparam int unsigned DEF_RECI_LAT = 8;
  localparam int unsigned DEF_MUL_LAT  = 3;

  localparam int unsigned TMR_W = 16;

  // The timer counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [TMR_W-1:0] lat_load(input int unsigned lat);
    return TMR_W'(lat - 1);
  endfunction

endpackage

// File: rtl/lat_timer.sv
// Down-counting phase timer: load a value, count to zero, flag the last cycle.
module lat_timer
  import softmax_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic [TMR_W-1:0] count_o,
  output logic             last_o
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)               count_d = load_val_i;
    else if (count_q != '0)   count_d = count_q - TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = (count_q == '0);

endmodule

// File: rtl/softmax_phase_sched.sv
// Sequences the exp / accumulate / reciprocal / multiply phases of a softmax
// over len elements, driving RAM and arithmetic-unit strobes as registered outputs.
module softmax_phase_sched
  import softmax_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned EXP_LAT  = DEF_EXP_LAT,
  parameter int unsigned ACC_LAT  = DEF_ACC_LAT,
  parameter int unsigned RECI_LAT = DEF_RECI_LAT,
  parameter int unsigned MUL_LAT  = DEF_MUL_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              ram1_rd_en,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic              ram2_wr_en,
  output logic [ADDR_W-1:0] ram2_wr_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              reci_start,
  output logic              ram2_rd_en,
  output logic [ADDR_W-1:0] ram2_rd_addr,
  output logic              ram3_wr_en,
  output logic [ADDR_W-1:0] ram3_addr,
  output logic [3:0]        sched_state
);

  localparam logic [ADDR_W:0]   LEN_ONE = 1;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;
  localparam logic [TMR_W-1:0]  CNT_ONE = 1;

  sched_state_e      state_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] i_q, j_q;
  logic              busy_q, done_q, acc_clr_q, acc_en_q, reci_start_q;
  logic              ram1_rd_en_q, ram2_wr_en_q, ram2_rd_en_q, ram3_wr_en_q;
  logic [ADDR_W-1:0] ram1_addr_q, ram2_wr_addr_q, ram2_rd_addr_q, ram3_addr_q;

  logic              tmr_load, tmr_last;
  logic [TMR_W-1:0]  tmr_val, tmr_cnt;
  logic              aborting, i_last, j_last;

  // Compare against len-1 so len = 2^ADDR_W never needs an index wrap.
  assign i_last   = ({1'b0, i_q} == len_q - LEN_ONE);
  assign j_last   = ({1'b0, j_q} == len_q - LEN_ONE);
  assign aborting = abort && (state_q != S_IDLE);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!aborting) begin
      case (state_q)
        S_READ:  begin tmr_load = 1'b1; tmr_val = lat_load(EXP_LAT); end
        S_EXPO:  if (tmr_last) begin tmr_load = 1'b1; tmr_val = lat_load(ACC_LAT); end
        S_ACC:   if (tmr_last && i_last) begin tmr_load = 1'b1; tmr_val = lat_load(RECI_LAT); end
        S_FETCH: begin tmr_load = 1'b1; tmr_val = lat_load(MUL_LAT); end
        default: ;
      endcase
    end
  end

  lat_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_cnt),
    .last_o     (tmr_last)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      i_q            <= '0;
      j_q            <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      acc_clr_q      <= 1'b0;
      acc_en_q       <= 1'b0;
      reci_start_q   <= 1'b0;
      ram1_rd_en_q   <= 1'b0;
      ram2_wr_en_q   <= 1'b0;
      ram2_rd_en_q   <= 1'b0;
      ram3_wr_en_q   <= 1'b0;
      ram1_addr_q    <= '0;
      ram2_wr_addr_q <= '0;
      ram2_rd_addr_q <= '0;
      ram3_addr_q    <= '0;
    end else begin
      // Strobes are single-cycle; addresses hold their last value.
      done_q       <= 1'b0;
      acc_clr_q    <= 1'b0;
      acc_en_q     <= 1'b0;
      reci_start_q <= 1'b0;
      ram1_rd_en_q <= 1'b0;
      ram2_wr_en_q <= 1'b0;
      ram2_rd_en_q <= 1'b0;
      ram3_wr_en_q <= 1'b0;
      if (aborting) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            busy_q <= 1'b1;
            if (len != '0) begin
              len_q        <= len;
              i_q          <= '0;
              j_q          <= '0;
              acc_clr_q    <= 1'b1;
              ram1_rd_en_q <= 1'b1;
              ram1_addr_q  <= '0;
              state_q      <= S_READ;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_READ: begin
            ram2_wr_en_q   <= (EXP_LAT == 1);
            ram2_wr_addr_q <= i_q;
            state_q        <= S_EXPO;
          end
          S_EXPO: if (tmr_last) begin
            acc_en_q <= 1'b1;
            state_q  <= S_ACC;
          end else if (tmr_cnt == CNT_ONE) begin
            ram2_wr_en_q   <= 1'b1;
            ram2_wr_addr_q <= i_q;
          end
          S_ACC: if (tmr_last) begin
            if (i_last) begin
              reci_start_q <= 1'b1;
              state_q      <= S_RECI;
            end else begin
              i_q          <= i_q + IDX_ONE;
              ram1_rd_en_q <= 1'b1;
              ram1_addr_q  <= i_q + IDX_ONE;
              state_q      <= S_READ;
            end
          end
          S_RECI: if (tmr_last) begin
            j_q            <= '0;
            ram2_rd_en_q   <= 1'b1;
            ram2_rd_addr_q <= '0;
            state_q        <= S_FETCH;
          end
          S_FETCH: state_q <= S_MULT;
          S_MULT: if (tmr_last) begin
            ram3_wr_en_q <= 1'b1;
            ram3_addr_q  <= j_q;
            state_q      <= S_STORE;
          end
          S_STORE: if (j_last) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            j_q            <= j_q + IDX_ONE;
            ram2_rd_en_q   <= 1'b1;
            ram2_rd_addr_q <= j_q + IDX_ONE;
            state_q        <= S_FETCH;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign acc_clr      = acc_clr_q;
  assign acc_en       = acc_en_q;
  assign reci_start   = reci_start_q;
  assign ram1_rd_en   = ram1_rd_en_q;
  assign ram1_addr    = ram1_addr_q;
  assign ram2_wr_en   = ram2_wr_en_q;
  assign ram2_wr_addr = ram2_wr_addr_q;
  assign ram2_rd_en   = ram2_rd_en_q;
  assign ram2_rd_addr = ram2_rd_addr_q;
  assign ram3_wr_en   = ram3_wr_en_q;
  assign ram3_addr    = ram3_addr_q;
  assign sched_state  = state_q;

endmodule

// File: tb/tb_softmax_phase_sched.sv
// Directed bench for softmax_phase_sched: default-latency instance plus an
// all-latencies-1 instance, with hand-computed cycle and address expectations.
module tb_softmax_phase_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [4:0] len = '0;
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [4:0] len1 = '0;

  logic       busy, done, ram1_rd_en, ram2_wr_en, acc_clr, acc_en, reci_start, ram2_rd_en, ram3_wr_en;
  logic [3:0] ram1_addr, ram2_wr_addr, ram2_rd_addr, ram3_addr, sched_state;
  logic       b_busy, b_done, b_ram1_rd_en, b_ram2_wr_en, b_acc_clr, b_acc_en, b_reci_start, b_ram2_rd_en, b_ram3_wr_en;
  logic [3:0] b_ram1_addr, b_ram2_wr_addr, b_ram2_rd_addr, b_ram3_addr, b_sched_state;

  int n_pass = 0, n_chk = 0;

  always #5 clk = ~clk;

  softmax_phase_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .ram1_rd_en(ram1_rd_en), .ram1_addr(ram1_addr),
    .ram2_wr_en(ram2_wr_en), .ram2_wr_addr(ram2_wr_addr), .acc_clr(acc_clr),
    .acc_en(acc_en), .reci_start(reci_start), .ram2_rd_en(ram2_rd_en),
    .ram2_rd_addr(ram2_rd_addr), .ram3_wr_en(ram3_wr_en), .ram3_addr(ram3_addr),
    .sched_state(sched_state)
  );

  softmax_phase_sched #(.ADDR_W(4), .EXP_LAT(1), .ACC_LAT(1), .RECI_LAT(1), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .len(len1), .abort(abort1),
    .busy(b_busy), .done(b_done), .ram1_rd_en(b_ram1_rd_en), .ram1_addr(b_ram1_addr),
    .ram2_wr_en(b_ram2_wr_en), .ram2_wr_addr(b_ram2_wr_addr), .acc_clr(b_acc_clr),
    .acc_en(b_acc_en), .reci_start(b_reci_start), .ram2_rd_en(b_ram2_rd_en),
    .ram2_rd_addr(b_ram2_rd_addr), .ram3_wr_en(b_ram3_wr_en), .ram3_addr(b_ram3_addr),
    .sched_state(b_sched_state)
  );

  wire [32:0] out_bus  = {busy, done, ram1_rd_en, ram2_wr_en, acc_clr, acc_en, reci_start,
                          ram2_rd_en, ram3_wr_en, ram1_addr, ram2_wr_addr, ram2_rd_addr,
                          ram3_addr, sched_state};
  wire [32:0] out_bus1 = {b_busy, b_done, b_ram1_rd_en, b_ram2_wr_en, b_acc_clr, b_acc_en,
                          b_reci_start, b_ram2_rd_en, b_ram3_wr_en, b_ram1_addr, b_ram2_wr_addr,
                          b_ram2_rd_addr, b_ram3_addr, b_sched_state};

  // Monitor for the default instance; cycle 0 is the cycle in which start is high.
  bit mon = 0;
  int cyc, done_at, n_done, n_acc, n_reci, n_clr, n_r2r, first_r2w, first_acc, first_reci;
  int q1[$], q2w[$], q3[$];
  int st_at [0:255];
  bit busy_at [0:255];
  bit sb_at [0:255];

  always @(negedge clk) if (mon) begin
    cyc++;
    if (cyc >= 0 && cyc < 256) begin
      st_at[cyc]   = int'(sched_state);
      busy_at[cyc] = busy;
      sb_at[cyc]   = |{ram1_rd_en, ram2_wr_en, ram2_rd_en, ram3_wr_en, acc_en, reci_start, acc_clr, done};
    end
    if (ram1_rd_en) q1.push_back(int'(ram1_addr));
    if (ram2_wr_en) begin q2w.push_back(int'(ram2_wr_addr)); if (first_r2w < 0) first_r2w = cyc; end
    if (ram3_wr_en) q3.push_back(int'(ram3_addr));
    if (ram2_rd_en) n_r2r++;
    if (acc_en) begin n_acc++; if (first_acc < 0) first_acc = cyc; end
    if (reci_start) begin n_reci++; if (first_reci < 0) first_reci = cyc; end
    if (acc_clr) n_clr++;
    if (done) begin n_done++; if (done_at < 0) done_at = cyc; end
  end

  // Monitor for the all-latencies-1 instance.
  bit mon1 = 0;
  int cyc1, done1_at, n_acc1, n_reci1, n_r3w1, n_clr1;

  always @(negedge clk) if (mon1) begin
    cyc1++;
    if (b_acc_en) n_acc1++;
    if (b_reci_start) n_reci1++;
    if (b_ram3_wr_en) n_r3w1++;
    if (b_acc_clr) n_clr1++;
    if (b_done && done1_at < 0) done1_at = cyc1;
  end

  function automatic bit ramp_ok(input int q[$], input int n);
    if (q.size() != n) return 1'b0;
    for (int k = 0; k < n; k++) if (q[k] != k) return 1'b0;
    return 1'b1;
  endfunction

  task automatic launch(input int l);
    @(posedge clk); #1;
    start = 1'b1; len = 5'(l);
    q1.delete(); q2w.delete(); q3.delete();
    cyc = -1; done_at = -1; n_done = 0; n_acc = 0; n_reci = 0; n_clr = 0; n_r2r = 0;
    first_r2w = -1; first_acc = -1; first_reci = -1;
    for (int k = 0; k < 256; k++) begin st_at[k] = -1; busy_at[k] = 1'b0; sb_at[k] = 1'b0; end
    mon = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit && done_at < 0; k++) begin @(negedge clk); #1; end
  endtask

  task automatic wait_cyc(input int n);
    for (int k = 0; k < 400 && cyc < n; k++) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_chk++; if (out_bus !== '0) $display("FAIL reset_outputs: got %h want 0", out_bus); else n_pass++;
    n_chk++; if (out_bus1 !== '0) $display("FAIL reset_outputs_fast: got %h want 0", out_bus1); else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (sched_state !== 4'd0 || busy !== 1'b0) $display("FAIL idle_after_reset: state %0d busy %0b want 0 0", sched_state, busy); else n_pass++;
  endtask

  task automatic test_len4;
    launch(4);
    wait_done(200);
    n_chk++; if (done_at != 57) $display("FAIL len4_done_cycle: got %0d want 57", done_at); else n_pass++;
    n_chk++; if (st_at[1] != 1 || st_at[2] != 2 || st_at[5] != 2 || st_at[6] != 3) $display("FAIL len4_states: c1 %0d c2 %0d c5 %0d c6 %0d want 1 2 2 3", st_at[1], st_at[2], st_at[5], st_at[6]); else n_pass++;
    n_chk++; if (first_r2w != 5 || first_acc != 6 || first_reci != 29) $display("FAIL len4_strobe_cycles: r2w %0d acc %0d reci %0d want 5 6 29", first_r2w, first_acc, first_reci); else n_pass++;
    n_chk++; if (!ramp_ok(q2w, 4)) $display("FAIL len4_ram2_writes: got %0d writes want 0..3", q2w.size()); else n_pass++;
    n_chk++; if (!ramp_ok(q3, 4)) $display("FAIL len4_ram3_writes: got %0d writes want 0..3", q3.size()); else n_pass++;
    n_chk++; if (!ramp_ok(q1, 4)) $display("FAIL len4_ram1_reads: got %0d reads want 0..3", q1.size()); else n_pass++;
    n_chk++; if (n_acc != 4 || n_reci != 1 || n_clr != 1 || n_r2r != 4) $display("FAIL len4_counts: acc %0d reci %0d clr %0d r2r %0d want 4 1 1 4", n_acc, n_reci, n_clr, n_r2r); else n_pass++;
    @(negedge clk); @(negedge clk);
    n_chk++; if (busy !== 1'b0 || sched_state !== 4'd0) $display("FAIL len4_back_idle: busy %0b state %0d want 0 0", busy, sched_state); else n_pass++;
  endtask

  task automatic test_len1_fast;
    @(posedge clk); #1;
    start1 = 1'b1; len1 = 5'd1;
    cyc1 = -1; done1_at = -1; n_acc1 = 0; n_reci1 = 0; n_r3w1 = 0; n_clr1 = 0; mon1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 50 && done1_at < 0; k++) begin @(negedge clk); #1; end
    n_chk++; if (done1_at != 8) $display("FAIL len1_done_cycle: got %0d want 8", done1_at); else n_pass++;
    n_chk++; if (n_acc1 != 1 || n_reci1 != 1 || n_r3w1 != 1 || n_clr1 != 1) $display("FAIL len1_counts: acc %0d reci %0d r3w %0d clr %0d want 1 1 1 1", n_acc1, n_reci1, n_r3w1, n_clr1); else n_pass++;
    mon1 = 1'b0;
  endtask

  task automatic test_len0;
    launch(0);
    wait_done(20);
    repeat (3) @(negedge clk);
    n_chk++; if (done_at != 1) $display("FAIL len0_done_cycle: got %0d want 1", done_at); else n_pass++;
    n_chk++; if (st_at[1] != 8 || busy_at[1] !== 1'b1) $display("FAIL len0_done_state: state %0d busy %0b want 8 1", st_at[1], busy_at[1]); else n_pass++;
    n_chk++; if (q1.size() + q2w.size() + q3.size() + n_r2r + n_acc + n_reci + n_clr != 0) $display("FAIL len0_no_strobes: got %0d strobes want 0", q1.size() + q2w.size() + q3.size() + n_r2r + n_acc + n_reci + n_clr); else n_pass++;
  endtask

  task automatic test_len16;
    launch(16);
    wait_done(400);
    n_chk++; if (done_at != 201) $display("FAIL len16_done_cycle: got %0d want 201", done_at); else n_pass++;
    n_chk++; if (!ramp_ok(q1, 16)) $display("FAIL len16_ram1_sweep: got %0d reads want 0..15", q1.size()); else n_pass++;
    n_chk++; if (!ramp_ok(q3, 16)) $display("FAIL len16_ram3_sweep: got %0d writes want 0..15", q3.size()); else n_pass++;
    n_chk++; if (!ramp_ok(q2w, 16)) $display("FAIL len16_ram2_sweep: got %0d writes want 0..15", q2w.size()); else n_pass++;
  endtask

  task automatic test_abort;
    launch(4);
    wait_cyc(48);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++; if (st_at[49] != 6 || st_at[50] != 0) $display("FAIL abort_state: c49 %0d c50 %0d want 6 0", st_at[49], st_at[50]); else n_pass++;
    n_chk++; if (busy_at[50] !== 1'b0 || sb_at[50] !== 1'b0) $display("FAIL abort_outputs: busy %0b strobes %0b want 0 0", busy_at[50], sb_at[50]); else n_pass++;
    n_chk++; if (n_done != 0 || q3.size() != 2) $display("FAIL abort_no_done: done %0d stores %0d want 0 2", n_done, q3.size()); else n_pass++;
    launch(2);
    wait_done(100);
    n_chk++; if (done_at != 33) $display("FAIL abort_restart_done: got %0d want 33", done_at); else n_pass++;
  endtask

  task automatic test_reset_mid_job;
    launch(4);
    wait_cyc(3);
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (out_bus !== '0) $display("FAIL midreset_outputs: got %h want 0", out_bus); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (80) @(negedge clk);
    n_chk++; if (n_done != 0 || busy !== 1'b0) $display("FAIL midreset_no_done: done %0d busy %0b want 0 0", n_done, busy); else n_pass++;
  endtask

  task automatic test_start_ignored;
    launch(4);
    wait_cyc(30);
    @(posedge clk); #1 start = 1'b1; len = 5'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100);
    n_chk++; if (done_at != 57) $display("FAIL start_ignored_done: got %0d want 57", done_at); else n_pass++;
    n_chk++; if (!ramp_ok(q3, 4)) $display("FAIL start_ignored_stores: got %0d stores want 0..3", q3.size()); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_len4;
    test_len1_fast;
    test_len0;
    test_len16;
    test_abort;
    test_reset_mid_job;
    test_start_ignored;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
